// File: rtl/tholin_mac_pkg.sv
// Shared types, default widths and sizing helpers for the Tholin MAC back end.
package tholin_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DEF_PROD_W   = 8;
  localparam int DEF_ACC_W    = 16;
  localparam int DEF_N_TERMS  = 4;
  localparam int DEF_CNT_W    = 4;
  localparam bit DEF_SATURATE = 1'b1;

  function automatic int calc_nb(input int acc_w);
    return (acc_w + 7) / 8;
  endfunction

  function automatic int calc_sel_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/tholin_sat_add.sv
// Accumulator adder: a + zero-extended b, with carry out and optional clamp to all-ones.
module tholin_sat_add #(
  parameter int ACC_W    = 16,
  parameter int PROD_W   = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [PROD_W-1:0] b_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full_s;

  assign full_s  = {1'b0, a_i} + (ACC_W+1)'(b_i);
  assign carry_o = full_s[ACC_W];
  assign sum_o   = (SATURATE && carry_o) ? {ACC_W{1'b1}} : full_s[ACC_W-1:0];

endmodule

// File: rtl/tt2_tholin_mac_accum.sv
// Sums N_TERMS products, then holds the result behind a valid/ready handshake
// with a byte-wide readout mux for the 8-bit user output bus.
module tt2_tholin_mac_accum
  import tholin_mac_pkg::*;
#(
  parameter int PROD_W   = DEF_PROD_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int N_TERMS  = DEF_N_TERMS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit SATURATE = DEF_SATURATE,
  localparam int NB      = calc_nb(ACC_W),
  localparam int SEL_W   = calc_sel_w(NB)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [SEL_W-1:0]  byte_sel,
  output logic [7:0]        out_byte,
  output logic              ovf,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic                out_valid_q, out_valid_d;
  logic                ovf_q, ovf_d;

  logic                accept_s;
  logic                last_s;
  logic [ACC_W-1:0]    sum_s;
  logic                carry_s;
  logic [8*NB-1:0]     result_pad_s;
  logic [7:0]          out_byte_s;

  tholin_sat_add #(
    .ACC_W   (ACC_W),
    .PROD_W  (PROD_W),
    .SATURATE(SATURATE)
  ) u_add (
    .a_i    (acc_q),
    .b_i    (prod),
    .sum_o  (sum_s),
    .carry_o(carry_s)
  );

  assign in_ready = (state_q != HOLD);
  assign accept_s = in_valid & in_ready;
  // With a single term every accept in IDLE is also the final one.
  assign last_s   = (N_TERMS == 1) ? (state_q == IDLE)
                                   : ((state_q == ACCUM) && (cnt_q == CNT_W'(N_TERMS - 1)));

  // Next-state logic: clear overrides the FSM, HOLD waits for the consumer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (clear) begin
      state_d     = IDLE;
      acc_d       = {ACC_W{1'b0}};
      cnt_d       = {CNT_W{1'b0}};
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept_s) begin
            ovf_d = ovf_q | carry_s;
            if (last_s) begin
              result_d    = sum_s;
              out_valid_d = 1'b1;
              acc_d       = {ACC_W{1'b0}};
              cnt_d       = {CNT_W{1'b0}};
              state_d     = HOLD;
            end else begin
              acc_d   = sum_s;
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ACCUM;
            end
          end else begin
            state_d = state_q;
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d     = IDLE;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          out_valid_d = 1'b0;
          ovf_d       = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      result_q    <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign result_pad_s = (8*NB)'(result_q);

  // Byte readout from the result register; selects past the top byte read zero.
  always_comb begin
    out_byte_s = 8'h00;
    for (int i = 0; i < NB; i++) begin
      out_byte_s = (byte_sel == SEL_W'(i)) ? result_pad_s[8*i +: 8] : out_byte_s;
    end
  end

  assign out_byte  = out_byte_s;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_tt2_tholin_mac_accum.sv
// Self-checking bench: four configurations driven by directed and randomized sums.
module tb_tt2_tholin_mac_accum;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] prod = 8'h00;
  logic [3:0] iv = 4'b0000;
  logic [3:0] ordy = 4'b0000;
  logic       clear = 1'b0;
  logic [1:0] bsel = 2'd0;

  logic       irdy [4];
  logic       ovld [4];
  logic [7:0] ob   [4];
  logic       ovf  [4];
  logic       bsy  [4];

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  tt2_tholin_mac_accum u0 (
    .clk(clk), .reset(reset), .prod(prod), .in_valid(iv[0]), .in_ready(irdy[0]),
    .clear(clear), .out_valid(ovld[0]), .out_ready(ordy[0]), .byte_sel(bsel[0:0]),
    .out_byte(ob[0]), .ovf(ovf[0]), .busy(bsy[0]));

  tt2_tholin_mac_accum #(.ACC_W(8), .N_TERMS(2), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset(reset), .prod(prod), .in_valid(iv[1]), .in_ready(irdy[1]),
    .clear(clear), .out_valid(ovld[1]), .out_ready(ordy[1]), .byte_sel(bsel[0:0]),
    .out_byte(ob[1]), .ovf(ovf[1]), .busy(bsy[1]));

  tt2_tholin_mac_accum #(.ACC_W(8), .N_TERMS(2), .SATURATE(1'b0)) u2 (
    .clk(clk), .reset(reset), .prod(prod), .in_valid(iv[2]), .in_ready(irdy[2]),
    .clear(clear), .out_valid(ovld[2]), .out_ready(ordy[2]), .byte_sel(bsel[0:0]),
    .out_byte(ob[2]), .ovf(ovf[2]), .busy(bsy[2]));

  tt2_tholin_mac_accum #(.ACC_W(24), .N_TERMS(1), .SATURATE(1'b1)) u3 (
    .clk(clk), .reset(reset), .prod(prod), .in_valid(iv[3]), .in_ready(irdy[3]),
    .clear(clear), .out_valid(ovld[3]), .out_ready(ordy[3]), .byte_sel(bsel),
    .out_byte(ob[3]), .ovf(ovf[3]), .busy(bsy[3]));

  // Reference: running sum with clamp or wrap, overflow flagged whenever a partial sum exceeds the width.
  function automatic void model(input int w, input bit sat, input int n, input int t[4],
                                output longint sum, output bit ovx);
    longint maxv = (longint'(1) << w) - 1;
    longint s;
    sum = 0;
    ovx = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = sum + t[i];
      if (s > maxv) begin
        ovx = 1'b1;
        s = sat ? maxv : (s % (maxv + 1));
      end
      sum = s;
    end
  endfunction

  task automatic push(input logic [3:0] mask, input logic [7:0] p);
    @(negedge clk);
    prod = p;
    iv   = mask;
    @(posedge clk);
    #1;
    iv = 4'b0000;
  endtask

  task automatic release_out(input int idx);
    @(negedge clk);
    ordy[idx] = 1'b1;
    @(posedge clk);
    #1;
    ordy[idx] = 1'b0;
    nchecks++; if (ovld[idx] !== 1'b0) begin nerr++; $display("FAIL rel_valid[%0d] got %0h exp 0", idx, ovld[idx]); end
    nchecks++; if (irdy[idx] !== 1'b1) begin nerr++; $display("FAIL rel_ready[%0d] got %0h exp 1", idx, irdy[idx]); end
    nchecks++; if (ovf[idx] !== 1'b0) begin nerr++; $display("FAIL rel_ovf[%0d] got %0h exp 0", idx, ovf[idx]); end
  endtask

  task automatic test_reset();
    bsel = 2'd0;
    #1;
    for (int i = 0; i < 4; i++) begin
      nchecks++; if (ovld[i] !== 1'b0) begin nerr++; $display("FAIL rst_valid[%0d] got %0h exp 0", i, ovld[i]); end
      nchecks++; if (irdy[i] !== 1'b1) begin nerr++; $display("FAIL rst_ready[%0d] got %0h exp 1", i, irdy[i]); end
      nchecks++; if (bsy[i] !== 1'b0) begin nerr++; $display("FAIL rst_busy[%0d] got %0h exp 0", i, bsy[i]); end
      nchecks++; if (ovf[i] !== 1'b0) begin nerr++; $display("FAIL rst_ovf[%0d] got %0h exp 0", i, ovf[i]); end
      nchecks++; if (ob[i] !== 8'h00) begin nerr++; $display("FAIL rst_byte[%0d] got %0h exp 00", i, ob[i]); end
    end
  endtask

  task automatic test_basic_sum();
    bsel = 2'd0;
    push(4'b0001, 8'd15);
    push(4'b0001, 8'd225);
    push(4'b0001, 8'd100);
    nchecks++; if (ovld[0] !== 1'b0) begin nerr++; $display("FAIL basic_early_valid got %0h exp 0", ovld[0]); end
    nchecks++; if (bsy[0] !== 1'b1) begin nerr++; $display("FAIL basic_busy got %0h exp 1", bsy[0]); end
    push(4'b0001, 8'd9);
    nchecks++; if (ovld[0] !== 1'b1) begin nerr++; $display("FAIL basic_valid got %0h exp 1", ovld[0]); end
    nchecks++; if (ob[0] !== 8'h5D) begin nerr++; $display("FAIL basic_sel0 got %0h exp 5d", ob[0]); end
    bsel = 2'd1;
    #1;
    nchecks++; if (ob[0] !== 8'h01) begin nerr++; $display("FAIL basic_sel1 got %0h exp 01", ob[0]); end
    nchecks++; if (ovf[0] !== 1'b0) begin nerr++; $display("FAIL basic_ovf got %0h exp 0", ovf[0]); end
    nchecks++; if (bsy[0] !== 1'b0) begin nerr++; $display("FAIL basic_idle_busy got %0h exp 0", bsy[0]); end
    bsel = 2'd0;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      push(4'b0001, 8'($urandom_range(1, 255)));
      nchecks++; if (irdy[0] !== 1'b0) begin nerr++; $display("FAIL hold_ready got %0h exp 0", irdy[0]); end
      nchecks++; if (ovld[0] !== 1'b1) begin nerr++; $display("FAIL hold_valid got %0h exp 1", ovld[0]); end
      nchecks++; if (ob[0] !== 8'h5D) begin nerr++; $display("FAIL hold_byte got %0h exp 5d", ob[0]); end
    end
    release_out(0);
  endtask

  task automatic test_clear();
    bsel = 2'd0;
    push(4'b0001, 8'd10);
    push(4'b0001, 8'd20);
    @(negedge clk);
    clear = 1'b1;
    iv    = 4'b0001;
    prod  = 8'd55;
    @(posedge clk);
    #1;
    clear = 1'b0;
    iv    = 4'b0000;
    nchecks++; if (bsy[0] !== 1'b0) begin nerr++; $display("FAIL clr_busy got %0h exp 0", bsy[0]); end
    nchecks++; if (irdy[0] !== 1'b1) begin nerr++; $display("FAIL clr_ready got %0h exp 1", irdy[0]); end
    for (int i = 0; i < 4; i++) push(4'b0001, 8'd1);
    nchecks++; if (ovld[0] !== 1'b1) begin nerr++; $display("FAIL clr_sum_valid got %0h exp 1", ovld[0]); end
    nchecks++; if (ob[0] !== 8'd4) begin nerr++; $display("FAIL clr_sum got %0h exp 04", ob[0]); end
    // Clearing a held result drops out_valid but leaves the readout intact.
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    nchecks++; if (ovld[0] !== 1'b0) begin nerr++; $display("FAIL clr_hold_valid got %0h exp 0", ovld[0]); end
    nchecks++; if (ob[0] !== 8'd4) begin nerr++; $display("FAIL clr_hold_byte got %0h exp 04", ob[0]); end
    nchecks++; if (irdy[0] !== 1'b1) begin nerr++; $display("FAIL clr_hold_ready got %0h exp 1", irdy[0]); end
  endtask

  task automatic test_saturate_wrap();
    bsel = 2'd0;
    push(4'b0110, 8'd200);
    push(4'b0110, 8'd100);
    nchecks++; if (ob[1] !== 8'hFF) begin nerr++; $display("FAIL sat_byte got %0h exp ff", ob[1]); end
    nchecks++; if (ovf[1] !== 1'b1) begin nerr++; $display("FAIL sat_ovf got %0h exp 1", ovf[1]); end
    nchecks++; if (ob[2] !== 8'h2C) begin nerr++; $display("FAIL wrap_byte got %0h exp 2c", ob[2]); end
    nchecks++; if (ovf[2] !== 1'b1) begin nerr++; $display("FAIL wrap_ovf got %0h exp 1", ovf[2]); end
    bsel = 2'd1;
    #1;
    nchecks++; if (ob[1] !== 8'h00) begin nerr++; $display("FAIL sat_sel_oob got %0h exp 00", ob[1]); end
    bsel = 2'd0;
    release_out(1);
    release_out(2);
  endtask

  task automatic test_single_term();
    bsel = 2'd0;
    push(4'b1000, 8'hC3);
    nchecks++; if (ovld[3] !== 1'b1) begin nerr++; $display("FAIL n1_valid got %0h exp 1", ovld[3]); end
    nchecks++; if (ob[3] !== 8'hC3) begin nerr++; $display("FAIL n1_sel0 got %0h exp c3", ob[3]); end
    bsel = 2'd3;
    #1;
    nchecks++; if (ob[3] !== 8'h00) begin nerr++; $display("FAIL n1_sel3 got %0h exp 00", ob[3]); end
    bsel = 2'd0;
    release_out(3);
  endtask

  task automatic rand_sum(input int idx, input int w, input bit sat, input int n);
    int         t [4];
    longint     s;
    bit         ovx;
    int         nb;
    logic [7:0] expb;
    logic [3:0] mask;
    mask = 4'(1 << idx);
    nb   = (w + 7) / 8;
    for (int i = 0; i < 4; i++) t[i] = int'($urandom_range(0, 255));
    model(w, sat, n, t, s, ovx);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      push(mask, 8'(t[i]));
    end
    nchecks++; if (ovld[idx] !== 1'b1) begin nerr++; $display("FAIL rnd_valid[%0d] got %0h exp 1", idx, ovld[idx]); end
    nchecks++; if (ovf[idx] !== ovx) begin nerr++; $display("FAIL rnd_ovf[%0d] got %0h exp %0h", idx, ovf[idx], ovx); end
    for (int b = 0; b < ((idx == 3) ? 4 : 2); b++) begin
      bsel = 2'(b);
      #1;
      expb = (b < nb) ? 8'((s >> (8 * b)) & 255) : 8'h00;
      nchecks++; if (ob[idx] !== expb) begin nerr++; $display("FAIL rnd_byte[%0d] sel %0d got %0h exp %0h", idx, b, ob[idx], expb); end
    end
    bsel = 2'd0;
    repeat ($urandom_range(1, 3)) push(mask, 8'($urandom_range(1, 255)));
    expb = 8'(s & 255);
    nchecks++; if (ob[idx] !== expb) begin nerr++; $display("FAIL rnd_hold[%0d] got %0h exp %0h", idx, ob[idx], expb); end
    release_out(idx);
  endtask

  task automatic test_async_reset();
    bsel = 2'd0;
    push(4'b0010, 8'd200);
    push(4'b0010, 8'd100);
    push(4'b0001, 8'd77);
    push(4'b0001, 8'd88);
    nchecks++; if (bsy[0] !== 1'b1) begin nerr++; $display("FAIL ar_pre_busy got %0h exp 1", bsy[0]); end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    nchecks++; if (bsy[0] !== 1'b0) begin nerr++; $display("FAIL ar_busy got %0h exp 0", bsy[0]); end
    nchecks++; if (ovld[0] !== 1'b0) begin nerr++; $display("FAIL ar_valid got %0h exp 0", ovld[0]); end
    nchecks++; if (ob[0] !== 8'h00) begin nerr++; $display("FAIL ar_byte got %0h exp 00", ob[0]); end
    nchecks++; if (irdy[0] !== 1'b1) begin nerr++; $display("FAIL ar_ready got %0h exp 1", irdy[0]); end
    nchecks++; if (ovf[1] !== 1'b0) begin nerr++; $display("FAIL ar_ovf1 got %0h exp 0", ovf[1]); end
    nchecks++; if (ovld[1] !== 1'b0) begin nerr++; $display("FAIL ar_valid1 got %0h exp 0", ovld[1]); end
    nchecks++; if (ob[1] !== 8'h00) begin nerr++; $display("FAIL ar_byte1 got %0h exp 00", ob[1]); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic_sum();
    test_hold();
    rand_sum(0, 16, 1'b1, 4);
    test_clear();
    test_saturate_wrap();
    test_single_term();
    for (int k = 0; k < 8; k++) begin
      rand_sum(0, 16, 1'b1, 4);
      rand_sum(1, 8, 1'b1, 2);
      rand_sum(2, 8, 1'b0, 2);
      rand_sum(3, 24, 1'b1, 1);
    end
    test_async_reset();
    for (int k = 0; k < 3; k++) begin
      rand_sum(0, 16, 1'b1, 4);
      rand_sum(1, 8, 1'b1, 2);
    end
    $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
    $finish;
  end

endmodule
